// File: rtl/if_fetch_ctrl_pkg.sv
// Shared definitions for the IF-stage fetch sequencer: FSM state encoding
// and default memory port widths.
package if_fetch_ctrl_pkg;

    localparam int DEFAULT_ADDR_WIDTH = 5;
    localparam int DEFAULT_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        START = 2'd1,
        RUN   = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/if_fetch_ctrl_pc_gen.sv
// PC generator: next-PC priority mux (start > redirect > stall > increment)
// plus the issued-PC and valid registers that tag each returned word.
module if_fetch_ctrl_pc_gen
    import if_fetch_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int RESET_PC   = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic                  run_i,
    input  logic                  stall_i,
    input  logic                  redirect_i,
    input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
    output logic [ADDR_WIDTH-1:0] next_pc_o,
    output logic [ADDR_WIDTH-1:0] issued_pc_o,
    output logic                  valid_o
);

    localparam logic [ADDR_WIDTH-1:0] ResetPc = ADDR_WIDTH'(RESET_PC);

    logic [ADDR_WIDTH-1:0] issued_pc_q, issued_pc_d, next_pc;
    logic                  valid_q, valid_d;

    // Stalling re-reads the current address so the memory output stays stable.
    always_comb begin
        next_pc     = issued_pc_q + ADDR_WIDTH'(1);
        issued_pc_d = issued_pc_q;
        valid_d     = 1'b0;
        if (start_i) begin
            next_pc = ResetPc;
        end else if (redirect_i) begin
            next_pc = redirect_pc_i;
        end else if (stall_i) begin
            next_pc = issued_pc_q;
        end
        if (start_i || run_i) begin
            issued_pc_d = next_pc;
            valid_d     = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            issued_pc_q <= ResetPc;
            valid_q     <= 1'b0;
        end else begin
            issued_pc_q <= issued_pc_d;
            valid_q     <= valid_d;
        end
    end

    assign next_pc_o   = next_pc;
    assign issued_pc_o = issued_pc_q;
    assign valid_o     = valid_q;

endmodule

// File: rtl/if_fetch_ctrl.sv
// IF-stage fetch sequencer: grants the instruction memory to the boot loader,
// then runs the PC sequence and tags returned words with PC and valid.
module if_fetch_ctrl
    import if_fetch_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int RESET_PC   = 0,
    parameter bit BOOT_LOAD  = 1'b1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  ld_valid_i,
    output logic                  ld_ready_o,
    input  logic [ADDR_WIDTH-1:0] ld_addr_i,
    input  logic [DATA_WIDTH-1:0] ld_data_i,
    input  logic                  ld_last_i,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic                  mem_we_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    input  logic                  stall_i,
    input  logic                  redirect_i,
    input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
    output logic [DATA_WIDTH-1:0] instr_o,
    output logic [ADDR_WIDTH-1:0] instr_pc_o,
    output logic                  instr_valid_o,
    output logic                  booting_o
);

    fetch_state_e state_q, state_d;

    logic [ADDR_WIDTH-1:0] next_pc;
    logic [ADDR_WIDTH-1:0] issued_pc;
    logic                  valid_q;
    logic                  in_load, in_start, in_run;

    assign in_load  = (state_q == LOAD);
    assign in_start = (state_q == START);
    assign in_run   = (state_q == RUN);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= BOOT_LOAD ? LOAD : START;
        end else begin
            state_q <= state_d;
        end
    end

    // Memory port belongs to the loader in LOAD and to the PC generator otherwise.
    always_comb begin
        state_d       = state_q;
        ld_ready_o    = 1'b0;
        mem_we_o      = 1'b0;
        mem_addr_o    = next_pc;
        mem_wdata_o   = ld_data_i;
        instr_valid_o = 1'b0;
        booting_o     = 1'b0;
        unique case (state_q)
            LOAD: begin
                ld_ready_o = 1'b1;
                mem_we_o   = ld_valid_i;
                mem_addr_o = ld_addr_i;
                booting_o  = 1'b1;
                if (ld_valid_i && ld_last_i) begin
                    state_d = START;
                end
            end
            START: begin
                booting_o = 1'b1;
                state_d   = RUN;
            end
            RUN: begin
                instr_valid_o = valid_q & ~redirect_i;
            end
            default: begin
                state_d = BOOT_LOAD ? LOAD : START;
            end
        endcase
    end

    if_fetch_ctrl_pc_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .RESET_PC   (RESET_PC)
    ) u_pc_gen (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .start_i       (in_start),
        .run_i         (in_run),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .next_pc_o     (next_pc),
        .issued_pc_o   (issued_pc),
        .valid_o       (valid_q)
    );

    assign instr_o    = mem_rdata_i;
    assign instr_pc_o = issued_pc;

    logic unused_load;
    assign unused_load = in_load;

endmodule
